// File: rtl/skeeball_game_ctrl_if.sv
// Lane-side bundle for the skeeball round controller: tick/start/hole stimulus in,
// score, counters and FSM status out. No backpressure; all signals are plain levels/pulses.
interface skeeball_game_ctrl_if;
  logic        tick;
  logic        start;
  logic [4:0]  hole;
  logic [15:0] score;
  logic [3:0]  balls_left;
  logic [6:0]  time_left;
  logic        lane_en;
  logic        game_over;
  logic [1:0]  state;

  modport master (
    output tick, start, hole,
    input  score, balls_left, time_left, lane_en, game_over, state
  );

  modport slave (
    input  tick, start, hole,
    output score, balls_left, time_left, lane_en, game_over, state
  );
endinterface

// File: rtl/skeeball_game_ctrl.sv
// Skeeball round controller: BCD scoring, ball and second countdown, IDLE/PLAY/SETTLE/OVER FSM.
// All outputs registered and updated on the edge that samples the input rise; inputs are never stalled.
module skeeball_game_ctrl #(
  parameter int NUM_BALLS     = 9,
  parameter int GAME_SECONDS  = 60,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                Reset,
  skeeball_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PLAY   = 2'b01,
    SETTLE = 2'b10,
    OVER   = 2'b11
  } state_t;

  state_t      state_q, nxt_state;
  logic [15:0] score_q, nxt_score;
  logic [3:0]  balls_q, nxt_balls;
  logic [6:0]  time_q, nxt_time;
  logic [7:0]  cnt_q, nxt_cnt;
  logic        start_q;
  logic [4:0]  hole_q;
  logic        lane_q, over_q;

  logic        start_rise;
  logic [4:0]  hole_rise;
  logic [3:0]  pts;
  logic [4:0]  tens_sum, tens_wrap;
  logic [3:0]  tens_n, hund_n, thou_n;
  logic        c_tens, c_hund;
  logic [15:0] score_add;

  assign start_rise = bus.start & ~start_q;
  assign hole_rise  = bus.hole & ~hole_q;

  // Highest-index rising sensor wins; ascending scan lets later bits overwrite earlier ones.
  always_comb begin
    pts = 4'd0;
    for (int i = 0; i < 5; i++) begin
      if (hole_rise[i]) pts = 4'(i + 1);
    end
  end

  always_comb begin
    tens_sum  = {1'b0, score_q[7:4]} + {1'b0, pts};
    tens_wrap = tens_sum - 5'd10;
    c_tens    = (tens_sum > 5'd9);
    tens_n    = c_tens ? tens_wrap[3:0] : tens_sum[3:0];
    c_hund    = c_tens && (score_q[11:8] == 4'd9);
    hund_n    = c_tens ? (c_hund ? 4'd0 : score_q[11:8] + 4'd1) : score_q[11:8];
    thou_n    = c_hund ? score_q[15:12] + 4'd1 : score_q[15:12];
    // Carry out of thousands means the total would exceed 9990; clamp there.
    if (c_hund && (score_q[15:12] == 4'd9)) score_add = 16'h9990;
    else                                    score_add = {thou_n, hund_n, tens_n, 4'h0};
  end

  always_comb begin
    nxt_state = state_q;
    nxt_score = score_q;
    nxt_balls = balls_q;
    nxt_time  = time_q;
    nxt_cnt   = cnt_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          nxt_score = 16'h0000;
          nxt_balls = 4'(NUM_BALLS);
          nxt_time  = 7'(GAME_SECONDS);
          nxt_cnt   = 8'd0;
          nxt_state = PLAY;
        end
      end
      PLAY: begin
        if (|hole_rise) begin
          nxt_score = score_add;
          nxt_balls = balls_q - 4'd1;
          nxt_cnt   = 8'(SETTLE_CYCLES);
          nxt_state = SETTLE;
        end
      end
      SETTLE: begin
        nxt_cnt = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          nxt_cnt   = 8'd0;
          nxt_state = (balls_q == 4'd0) ? OVER : PLAY;
        end
      end
      default: nxt_state = IDLE;
    endcase
    // Running out of time overrides whatever the ball/settle logic chose.
    if ((state_q == PLAY || state_q == SETTLE) && bus.tick && time_q != 7'd0) begin
      nxt_time = time_q - 7'd1;
      if (time_q == 7'd1) nxt_state = OVER;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      score_q <= 16'h0000;
      balls_q <= 4'd0;
      time_q  <= 7'd0;
      cnt_q   <= 8'd0;
      start_q <= 1'b1;
      hole_q  <= 5'b11111;
      lane_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= nxt_state;
      score_q <= nxt_score;
      balls_q <= nxt_balls;
      time_q  <= nxt_time;
      cnt_q   <= nxt_cnt;
      start_q <= bus.start;
      hole_q  <= bus.hole;
      lane_q  <= (nxt_state == PLAY);
      over_q  <= (nxt_state == OVER);
    end
  end

  assign bus.state      = state_q;
  assign bus.score      = score_q;
  assign bus.balls_left = balls_q;
  assign bus.time_left  = time_q;
  assign bus.lane_en    = lane_q;
  assign bus.game_over  = over_q;

endmodule

// File: doc/skeeball_game_ctrl.md
# skeeball_game_ctrl

Game-round controller for the skeeball lane. It starts a round on a start-button press and arms the lane. It scores hole-sensor hits into a 4-digit BCD total, counts balls, and counts the round time down from a 1 Hz tick produced by the lane's clock-divider chain. It ends the round and flags game-over when either balls or time run out.

## Interface
Parameters:
- NUM_BALLS, 9, balls per round (1-15)
- GAME_SECONDS, 60, round length in seconds (1-127)
- SETTLE_CYCLES, 16, clk cycles during which hole sensors are ignored after a scored hit (1-255)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- Reset  in  1  asynchronous, active-high reset
- tick  in  1  one-clk-wide pulse, once per second, synchronous to clk
- start  in  1  start button level, already synchronized and debounced
- hole  in  5  hole sensor levels, synchronized; bit i worth 10*(i+1) points
- score  out  16  BCD {thousands, hundreds, tens, ones}; ones digit always 0
- balls_left  out  4  balls remaining, binary
- time_left  out  7  seconds remaining, binary
- lane_en  out  1  high only in PLAY (ball release gate)
- game_over  out  1  high only in OVER
- state  out  2  current FSM state

## Operation
- Edge detect: each of start and hole[4:0] has a previous-sample register. A rise is the input at 1 now with its previous sample at 0. Previous-sample registers reset to all ones, so an input held high through reset never fires.
- FSM encoding: IDLE=00, PLAY=01, SETTLE=10, OVER=11.
- IDLE/OVER, start rise:
  - score=0, balls_left=NUM_BALLS, time_left=GAME_SECONDS, settle counter=0.
  - Next state PLAY.
  - Hole rises and tick are ignored in these states.
- PLAY, any hole rise:
  - The highest-index rising bit wins; all other rising bits are discarded.
  - Add (i+1) to the tens digit in BCD, with carry into hundreds and thousands.
  - Saturate at 9990 (score stays 16'h9990).
  - balls_left decrements. Settle counter loads SETTLE_CYCLES. Next state SETTLE.
- SETTLE:
  - Hole rises are ignored.
  - The counter decrements each cycle. When it reaches 0, next state is OVER if balls_left==0, else PLAY.
- tick in PLAY or SETTLE: time_left decrements. If time_left was 1, next state is OVER, overriding any other transition.
- Simultaneous tick and hole rise in PLAY: both apply on the same edge. The score is added and the ball counted; then the time rule decides the state (OVER if time_left was 1).
- start rise during PLAY or SETTLE: ignored.
- OVER: score, balls_left and time_left hold until the next start rise.

## Timing
- All outputs are registered; no combinational path from input to output.
- Latency: an input rise sampled at edge k updates score, balls_left, time_left and state at edge k, so new values are visible after edge k.
- SETTLE lasts exactly SETTLE_CYCLES clock cycles after the scoring edge.
- Reset values, applied immediately and asynchronously:
  - state=IDLE, score=0, balls_left=0, time_left=0, lane_en=0, game_over=0.
  - Settle counter=0; previous-sample registers=1.
- Reset mid-round abandons the round with no partial update and returns to IDLE.
- lane_en and game_over are decoded from registered state, so they change on the same edge as state.

## Test plan
- Reset, then raise start -> state=PLAY, balls_left=9, time_left=60, score=0, lane_en=1.
- Rise hole[4] -> score=16'h0050, balls_left=8, state=SETTLE for 16 cycles, then PLAY. A hole[0] rise during SETTLE leaves score=16'h0050.
- hole[1] and hole[3] rise on the same edge -> score increases by 40 only; balls_left decreases by 1.
- Score 9 balls, alternating hole[4] and hole[0] (5×50 + 4×10) -> score=16'h0290, balls_left=0, SETTLE then OVER. Result: game_over=1, lane_en=0.
- 60 ticks with no hits -> time_left=0, OVER after the 60th tick. A tick and a hole[2] rise on the same edge with time_left=1 -> score +30 and OVER on that edge.
- Hold hole[0] high through Reset release, then start a round -> no score until hole[0] falls and rises again. Assert Reset in SETTLE -> all outputs at reset values immediately.
